// File: rtl/if_capture_pkg.sv
// rtl/if_capture_pkg.sv - shared state encoding and IF buffer geometry
package if_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int IF_ADDR_WIDTH = 11;
  localparam int IF_DATA_WIDTH = 12;
  localparam int IF_FRAME_LEN  = 1500;

endpackage

// File: rtl/if_data_capture_rise_edge_det.sv
// rtl/if_data_capture_rise_edge_det.sv - registered rising-edge detector for the trigger
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/if_data_capture.sv
// rtl/if_data_capture.sv - armed, triggered single-frame writer into the IF sample RAM
module if_data_capture
  import if_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
  parameter int DATA_WIDTH = IF_DATA_WIDTH,
  parameter int FRAME_LEN  = IF_FRAME_LEN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sample_cnt,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  trig_miss
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  cap_state_t state;
  logic       trig_edge;
  logic       accept;
  logic       last;

  rise_edge_det u_trig_edge (
    .clk   (clk),
    .rst   (rst),
    .level (trig),
    .rise  (trig_edge)
  );

  // The trigger-edge cycle itself may carry the first sample of the frame.
  assign accept = s_valid && ((state == ARMED && trig_edge) || state == CAPTURE);
  assign last   = accept && (sample_cnt == LAST_ADDR);
  assign ram_wea = ram_ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ram_ena    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      trig_miss  <= 1'b0;
    end else begin
      ram_ena   <= 1'b0;
      trig_miss <= trig_edge && (state == CAPTURE || state == DONE);
      if (abort) begin
        state      <= IDLE;
        sample_cnt <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        if (accept) begin
          ram_ena    <= 1'b1;
          ram_addra  <= sample_cnt;
          ram_dina   <= s_data;
          sample_cnt <= sample_cnt + 1'b1;
        end
        unique case (state)
          IDLE: if (arm) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
          ARMED: if (trig_edge) state <= CAPTURE;
          CAPTURE: ;
          DONE: if (arm) begin
            state      <= ARMED;
            sample_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        endcase
        // Overrides ARMED->CAPTURE so a one-sample frame still completes.
        if (last) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/if_data_capture.md
Name: if_data_capture

Overview:
Writer for the IF sample buffer. Once armed, it detects a trigger edge and writes one frame of FRAME_LEN consecutive valid 12-bit IF samples into the block-RAM write port (clka/ena/wea/addra/dina style). It then reports completion so downstream pulse-compression logic, or a bench, can read the buffer back. It sits between the ADC sample stream and the IF data RAM.

Parameters:
ADDR_WIDTH, 11, RAM address width; 2^ADDR_WIDTH must be at least FRAME_LEN.
DATA_WIDTH, 12, IF sample width.
FRAME_LEN, 1500, samples per captured frame.
CNT_WIDTH, 16, width of the frame counter.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
arm  in  1  single-cycle pulse that arms a capture.
abort  in  1  single-cycle pulse that cancels any capture and returns to IDLE.
trig  in  1  trigger level; the block acts on its rising edge.
s_valid  in  1  input sample qualifier.
s_data  in  DATA_WIDTH  input IF sample.
ram_ena  out  1  RAM enable.
ram_wea  out  1  RAM write enable; always equal to ram_ena.
ram_addra  out  ADDR_WIDTH  RAM write address.
ram_dina  out  DATA_WIDTH  RAM write data.
busy  out  1  high in ARMED or CAPTURE.
done  out  1  high in DONE.
sample_cnt  out  ADDR_WIDTH  samples written in the current frame.
frame_cnt  out  CNT_WIDTH  number of frames completed.
trig_miss  out  1  one-cycle pulse on a trigger edge that arrives in CAPTURE or DONE.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, and the trig edge register is cleared to 0.
- Edge detect: trig_q is the registered copy of trig. edge = trig & ~trig_q is evaluated in the current cycle.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: arm -> ARMED. A trigger edge is ignored and does not raise trig_miss.
  - ARMED: edge -> CAPTURE. If s_valid is high in the edge cycle, that sample is written at address 0. arm has no effect.
  - CAPTURE: each cycle with s_valid high writes s_data at address sample_cnt, then sample_cnt increments. Gaps in s_valid are allowed and need no timeout. The FRAME_LEN-th write moves the state to DONE; frame_cnt increments at the same time and wraps from 2^CNT_WIDTH-1 to 0. arm is ignored. An edge pulses trig_miss.
  - DONE: done=1. arm -> ARMED and clears sample_cnt to 0 in the same transition. An edge pulses trig_miss.
  - abort in any state -> IDLE. No write is issued for a sample presented in the abort cycle. sample_cnt is cleared; frame_cnt is kept.
  - If abort and arm arrive together, abort wins.
- Write timing: RAM outputs are registered.
  - A sample accepted in cycle N produces ram_ena=ram_wea=1, ram_addra=address, ram_dina=sample in cycle N+1. Writes from consecutive accepted samples are issued back to back.
  - ram_ena is low in every other cycle. While it is low, ram_addra and ram_dina hold their last values.
  - The final write of a frame occurs in the first cycle of DONE.
- Only addresses 0..FRAME_LEN-1 are ever written. sample_cnt never exceeds FRAME_LEN.
- Reset mid-capture: no write in the cycle after the reset cycle. A fresh arm is required afterwards.
- busy = (ARMED or CAPTURE). Both busy and done are registered from the state.

Decomposition:
- Shared package if_capture_pkg holds:
  - the state encoding (IDLE, ARMED, CAPTURE, DONE);
  - the IF_ADDR_WIDTH = 11, IF_DATA_WIDTH = 12 and IF_FRAME_LEN = 1500 constants, which are shared with the ROM and RAM cores and the benches.
- One sub-module, rise_edge_det (registered rising-edge detector), is natural and reusable for the trigger.
- The FSM, counters and write register stay in the top module.

Test Plan:
1. Basic frame: rst for 2 cycles, arm, trig edge, then 1500 consecutive s_valid with s_data = index mod 4096. Expect 1500 writes with addr = data = 0..1499, done=1 after the last write, frame_cnt=1, sample_cnt=1500.
2. Gapped input: s_valid asserted every third cycle. Expect writes still contiguous at addresses 0..1499, each write one cycle after its accepted sample, and ram_ena never high twice for one sample.
3. Unarmed trigger: trig edges in IDLE with s_valid high. Expect ram_ena=0 throughout, trig_miss=0 and busy=0.
4. Late trigger: a second trig edge at sample 700 of capture, and again while done=1. Expect a one-cycle trig_miss pulse each time, with addresses undisturbed (sample 701 written at address 701).
5. Interruptions: abort at sample 500 -> IDLE, no further writes, frame_cnt unchanged. Separately, rst at sample 700 -> all outputs 0 on the next cycle, and a later arm+trig captures from address 0.
6. Re-arm: after one frame, arm, trig, 1500 samples of value 12'hABC. Expect all addresses overwritten with 12'hABC, frame_cnt=2, and done deasserted during the second capture.
